bcd_7seg_scan: RTL and testbench

Time-multiplexed 7-segment display driver that consumes the packed BCD word produced by the binary-to-BCD converter. It latches a BCD value on a load strobe and scans the digits one at a time onto a shared active-low segment bus with per-digit active-low anode enables. A guard interval between digit slots suppresses ghosting. Out-of-range nibbles are shown as a dash.

---
 rtl/bcd_7seg_scan.sv | 128 ++++++++++++
 tb/tb_bcd_7seg_scan.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: time-multiplexed, active-low 7-segment driver for a packed BCD word.
// A load strobe captures the BCD value into a shadow register. A prescaler walks a digit index
// across the anodes, and every slot opens with a blanked guard interval to suppress ghosting.
// Nibbles A-F are shown as a dash.
// Optional feature: define BCD7SEG_LZB_EN to blank leading zero digits. Digit 0 is always shown.
module bcd_7seg_scan #(
  parameter int unsigned BCD_DIGITS = 3,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned GUARD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BCD_DIGITS*4-1:0] bcd,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [BCD_DIGITS-1:0]   an
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD_CYC);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(BCD_DIGITS - 1);
  localparam logic [6:0]      SegBlank = 7'h7F;
  localparam logic [6:0]      SegDash  = 7'b0111111;

  logic [BCD_DIGITS*4-1:0] shd_q, shd_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [BCD_DIGITS-1:0]   an_q, an_d;

  logic [BCD_DIGITS-1:0]   lzb;
  logic [3:0]              cur_nib;
  logic                    cur_blank;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD nibble
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SegDash;
    endcase
    return pat;
  endfunction

  // Next state for the shadow register, prescaler and digit index
  always_comb begin
    shd_d = load ? bcd : shd_q;
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef BCD7SEG_LZB_EN
  // Digit i (i >= 1) is blanked while it and every more significant nibble are zero
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lzb        = '0;
    for (int i = int'(BCD_DIGITS) - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shd_q[i*4 +: 4] == 4'd0);
      lzb[i]     = upper_zero;
    end
  end
`else
  // Every digit is displayed, leading zeros included
  assign lzb = '0;
`endif

  // Select the nibble and blanking flag of the digit currently being scanned
  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = shd_q[i*4 +: 4];
        cur_blank = lzb[i];
      end
    end
  end

  // Pin values: dark during the guard interval, else one anode low with its decoded pattern
  always_comb begin
    seg_d = SegBlank;
    an_d  = '1;
    if (cnt_q >= GuardCnt) begin
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
        an_d[i] = (idx_q != IdxW'(i));
      end
      // A blanked digit keeps its anode asserted and drives all segments off
      seg_d = cur_blank ? SegBlank : seg_decode(cur_nib);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SegBlank;
      an_q  <= '1;
    end else begin
      shd_q <= shd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan with 3 digits, 4-cycle slots and a 1-cycle guard.
// Expected {an, seg} values are queued as stimulus is driven and compared on the falling edge.
module tb_bcd_7seg_scan;

  localparam int DIG = 3;
  localparam int DIV = 4;
  localparam int GRD = 1;

  localparam logic [9:0] PinBlank = {3'b111, 7'h7F};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [11:0] bcd = 12'h000;
  logic [6:0]  seg;
  logic [2:0]  an;

  bcd_7seg_scan #(
    .BCD_DIGITS(DIG),
    .SCAN_DIV  (DIV),
    .GUARD_CYC (GRD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bcd  (bcd),
    .load (load),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  logic [9:0] sb_q[$];
  string      tag_q[$];
  int         total = 0;
  int         bad = 0;

  // Reference state
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [11:0] m_shd = 12'h000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Drive one cycle of inputs, queue the expected pins after the next edge, advance the model.
  // When use_c is set, the caller-supplied constant is queued instead of the model prediction.
  task automatic step(input string tag, input logic r, input logic l, input logic [11:0] b,
                      input logic use_c, input logic [9:0] c);
    logic [9:0] e;
    logic [2:0] a;
    logic [6:0] s;
    rst_n = r;
    load  = l;
    bcd   = b;
    if (!r || m_cnt < GRD) begin
      e = PinBlank;
    end else begin
      a = 3'b111;
      a[m_idx] = 1'b0;
      s = ref_seg(m_shd[m_idx*4 +: 4]);
`ifdef BCD7SEG_LZB_EN
      if (m_idx >= 1 && (m_shd >> (4 * m_idx)) == 12'h000) s = 7'h7F;
`endif
      e = {a, s};
    end
    sb_q.push_back(use_c ? c : e);
    tag_q.push_back(tag);
    if (!r) begin
      m_cnt = 0;
      m_idx = 0;
      m_shd = 12'h000;
    end else begin
      if (l) m_shd = b;
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == DIG - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 12'h000, 1'b0, 10'h0);
  endtask

  // Compare the DUT pins against the oldest queued expectation, away from the rising edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      check_val(tag_q.pop_front(), {29'd0, an} << 7 | {25'd0, seg}, {22'd0, sb_q.pop_front()});
    end
  end

  logic [9:0] scan_exp[14];

  initial begin
    scan_exp = '{PinBlank, {3'b110, 7'b0110000}, {3'b110, 7'b0110000}, {3'b110, 7'b0110000},
                 PinBlank, {3'b101, 7'b0100100}, {3'b101, 7'b0100100}, {3'b101, 7'b0100100},
                 PinBlank, {3'b011, 7'b1111001}, {3'b011, 7'b1111001}, {3'b011, 7'b1111001},
                 PinBlank, {3'b110, 7'b0110000}};

    // Reset held with load active: pins stay dark and the load is ignored
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 12'h999, 1'b1, PinBlank);
    run("post_reset_frame", 12);

    // Scan of 123 from a slot boundary, including the wrap back to the ones digit
    step("scan", 1'b1, 1'b1, 12'h123, 1'b1, scan_exp[0]);
    for (int i = 1; i < 14; i++) step("scan", 1'b1, 1'b0, 12'h000, 1'b1, scan_exp[i]);
    run("scan_tail", 10);

    // Leading zeros
    step("blank_007", 1'b1, 1'b1, 12'h007, 1'b0, 10'h0);
    run("blank_007", 11);

    // Invalid tens nibble shows a dash
    step("invalid_0a5", 1'b1, 1'b1, 12'h0A5, 1'b0, 10'h0);
    run("invalid_0a5", 11);

    // Load during the lit ones window changes seg one cycle later
    step("midload", 1'b1, 1'b1, 12'h009, 1'b1, PinBlank);
    step("midload", 1'b1, 1'b0, 12'h000, 1'b1, {3'b110, 7'b0010000});
    step("midload", 1'b1, 1'b1, 12'h004, 1'b1, {3'b110, 7'b0010000});
    step("midload", 1'b1, 1'b0, 12'h000, 1'b1, {3'b110, 7'b0011001});
    run("midload_rest", 8);

    // Reset dropped while the hundreds digit is lit; shadow is lost and scan restarts
    step("midreset_ld", 1'b1, 1'b1, 12'h321, 1'b0, 10'h0);
    run("midreset_pre", 9);
    step("midreset", 1'b0, 1'b0, 12'h000, 1'b1, PinBlank);
    step("midreset", 1'b0, 1'b1, 12'h555, 1'b1, PinBlank);
    step("restart", 1'b1, 1'b0, 12'h000, 1'b1, PinBlank);
    step("restart", 1'b1, 1'b0, 12'h000, 1'b1, {3'b110, 7'b1000000});
    run("restart_rest", 10);

    @(negedge clk);
    #1;
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
